// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, FSM state encoding and decoded control bundle shared by
// the BIP controller and datapath-side logic.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic       hlt;
        logic       rd_mem;
        logic       wr_mem;
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode-to-control decode; unknown opcodes decode
// to all-zero controls so they execute as NOPs.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] opcode_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_HLT: ctrl_o.hlt = 1'b1;
            OP_STO: ctrl_o.wr_mem = 1'b1;
            OP_LD: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.rd_mem = 1'b1;
                ctrl_o.sel_a  = SEL_A_MEM;
            end
            OP_LDI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_A_IMM;
            end
            OP_ADD, OP_SUB: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.rd_mem = 1'b1;
                ctrl_o.sel_a  = SEL_A_ALU;
                ctrl_o.op     = (opcode_i == OP_ADD);
            end
            OP_ADDI, OP_SUBI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_A_ALU;
                ctrl_o.sel_b  = 1'b1;
                ctrl_o.op     = (opcode_i == OP_ADDI);
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// bip_control: BIP fetch/decode/execute sequencer with PC and instruction register.
// Optional saturating cycle counter enabled by defining BIP_CONTROL_CYCLE_COUNTER_EN.
module bip_control
    import bip_pkg::*;
#(
    parameter int NB_DATA            = 16,
    parameter int NB_OPCODE          = 5,
    parameter int NB_OPERAND         = 11,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int LOG2_N_DATA_ADDR   = 10,
    parameter int NB_SEL_A           = 2,
    parameter int NB_DATA_S_EXT      = 10,
    parameter int NB_CYCLES          = 32
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic                          i_start,
    input  logic [NB_DATA-1:0]            i_instruction,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_pc,
    output logic                          o_rd_insmem,
    output logic [LOG2_N_DATA_ADDR-1:0]   o_data_addr,
    output logic                          o_rd_datamem,
    output logic                          o_wr_datamem,
    output logic [NB_DATA_S_EXT-1:0]      o_data_instruction,
    output logic [NB_SEL_A-1:0]           o_sel_a,
    output logic                          o_sel_b,
    output logic                          o_wr_acc,
    output logic                          o_op_code,
    output logic                          o_halt,
    output logic [NB_CYCLES-1:0]          o_cycles
);

    state_e                        state_q, state_d;
    logic [LOG2_N_INSMEM_ADDR-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0]            ir_q, ir_d;
    logic [NB_DATA-1:0]            cur_ins;
    logic                          in_dec, in_exec;
    logic                          unused_operand;
    ctrl_t                         ctrl;

    assign in_dec  = (state_q == ST_DECODE);
    assign in_exec = (state_q == ST_EXEC);
    // Memory data arrives during DECODE, before the IR holds it, so decode it directly.
    assign cur_ins = in_dec ? i_instruction : ir_q;

    bip_decoder u_decoder (
        .opcode_i (cur_ins[NB_DATA-1 -: NB_OPCODE]),
        .ctrl_o   (ctrl)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (i_valid) begin
            case (state_q)
                ST_IDLE:  state_d = i_start ? ST_FETCH : ST_IDLE;
                ST_FETCH: state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d    = i_instruction;
                    state_d = ctrl.hlt ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + LOG2_N_INSMEM_ADDR'(1);
                end
                default:  state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign o_pc               = pc_q;
    assign o_rd_insmem        = i_valid && (state_q == ST_FETCH);
    assign o_rd_datamem       = i_valid && in_dec && ctrl.rd_mem;
    assign o_wr_datamem       = i_valid && in_exec && ctrl.wr_mem;
    assign o_wr_acc           = i_valid && in_exec && ctrl.wr_acc;
    assign o_sel_a            = in_exec ? ctrl.sel_a : '0;
    assign o_sel_b            = in_exec && ctrl.sel_b;
    assign o_op_code          = in_exec && ctrl.op;
    assign o_halt             = (state_q == ST_HALT);
    assign o_data_addr        = cur_ins[LOG2_N_DATA_ADDR-1:0];
    assign o_data_instruction = cur_ins[NB_DATA_S_EXT-1:0];
    assign unused_operand     = ^cur_ins[NB_OPERAND-1:LOG2_N_DATA_ADDR];

`ifdef BIP_CONTROL_CYCLE_COUNTER_EN
    logic [NB_CYCLES-1:0] cycles_q, cycles_d;

    assign cycles_d = (i_valid && (state_q inside {ST_FETCH, ST_DECODE, ST_EXEC}) && !(&cycles_q))
                    ? cycles_q + NB_CYCLES'(1) : cycles_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) cycles_q <= '0;
        else          cycles_q <= cycles_d;
    end

    assign o_cycles = cycles_q;
`else
    assign o_cycles = '0;
`endif

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameters SHALL be: NB_DATA 16, instruction width; NB_OPCODE 5, opcode field; NB_OPERAND 11, operand field; LOG2_N_INSMEM_ADDR 11, PC width; LOG2_N_DATA_ADDR 10, data address width; NB_SEL_A 2, sel_a width; NB_DATA_S_EXT 10, immediate width to datapath; NB_CYCLES 32, cycle counter width.
REQ-002 Ports SHALL be:
- i_clock  input  1  clock, all state on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  step enable; when 0, all state holds.
- i_start  input  1  leave IDLE and begin execution.
- i_instruction  input  NB_DATA  instruction memory read data, 1-cycle synchronous latency.
- o_pc  output  LOG2_N_INSMEM_ADDR  instruction address.
- o_rd_insmem  output  1  instruction read strobe.
- o_data_addr  output  LOG2_N_DATA_ADDR  data memory address.
- o_rd_datamem / o_wr_datamem  output  1 each  data memory read/write strobes.
- o_data_instruction  output  NB_DATA_S_EXT  immediate to the datapath.
- o_sel_a  output  NB_SEL_A; o_sel_b, o_wr_acc, o_op_code  output  1 each  datapath controls.
- o_halt  output  1  program finished.
- o_cycles  output  NB_CYCLES  executed-cycle count.

Function
REQ-003 Instruction fields SHALL be opcode = bits[15:11] and operand = bits[10:0]; o_data_addr SHALL be operand[LOG2_N_DATA_ADDR-1:0]; o_data_instruction SHALL be operand[NB_DATA_S_EXT-1:0].
REQ-004 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, HALT; transitions occur only when i_valid=1.
- IDLE->FETCH on i_start.
- FETCH->DECODE unconditionally.
- DECODE->EXEC unconditionally.
- EXEC->FETCH unconditionally.
- Any state->HALT when HLT is decoded in DECODE.
- HALT stays in HALT until reset.
REQ-005 FETCH SHALL assert o_rd_insmem for one cycle with o_pc stable; DECODE SHALL latch i_instruction into the instruction register.
REQ-006 DECODE SHALL assert o_rd_datamem for LD/ADD/SUB so that data is valid in EXEC.
REQ-007 EXEC SHALL drive the controls for one cycle from the opcode:
- HLT 00000: never reaches EXEC.
- STO 00001: o_wr_datamem=1.
- LD 00010: wr_acc=1, sel_a=00.
- LDI 00011: wr_acc=1, sel_a=01.
- ADD 00100: wr_acc=1, sel_a=10, sel_b=0, op=1.
- ADDI 00101: wr_acc=1, sel_a=10, sel_b=1, op=1.
- SUB 00110: wr_acc=1, sel_a=10, sel_b=0, op=0.
- SUBI 00111: wr_acc=1, sel_a=10, sel_b=1, op=0.
REQ-008 Undefined opcodes SHALL execute as NOP: no write strobes; PC still advances.
REQ-009 o_wr_acc, o_wr_datamem, o_rd_datamem and o_rd_insmem SHALL be 0 in every state not listed above, and whenever i_valid=0.
REQ-010 PC SHALL increment by 1 at the end of EXEC, modulo 2^LOG2_N_INSMEM_ADDR (2047 wraps to 0).
REQ-011 o_halt SHALL be 1 exactly while in HALT; PC SHALL be frozen at the HLT address.
REQ-012 Each instruction SHALL take exactly 3 valid cycles: FETCH, DECODE, EXEC.
REQ-013 If i_start is asserted outside IDLE, it SHALL be ignored.

Reset
REQ-014 While i_reset=0, the block SHALL asynchronously hold: state IDLE, PC 0, instruction register 0, o_cycles 0, o_halt 0, all strobes and controls 0.
REQ-015 Reset asserted mid-instruction SHALL abort the instruction; no partial write strobe SHALL occur after assertion.

Configuration
REQ-016 With BIP_CONTROL_CYCLE_COUNTER_EN defined, o_cycles SHALL count valid cycles spent outside IDLE and HALT, saturating at all-ones.
REQ-017 Without BIP_CONTROL_CYCLE_COUNTER_EN, o_cycles SHALL be constant 0 and no counter register SHALL be inferred.

Structure
REQ-018 The opcode localparams and state encodings SHALL live in a shared package bip_pkg, which bip_datapath-side logic also uses.
REQ-019 Opcode-to-control decoding SHALL be a combinational sub-module bip_decoder; PC, instruction register, FSM and counter SHALL stay in bip_control.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then i_start=1: o_pc=0, o_rd_insmem=1 in the next cycle; program LDI 5; ADDI 3; HLT: the cycle-by-cycle controls match REQ-007, o_halt=1 with o_pc=2, and with the macro defined o_cycles=8.
- STO 0x3FF: o_wr_datamem=1 for one cycle in EXEC with o_data_addr=0x3FF; o_wr_acc=0.
- SUB 7 after LD 7: o_rd_datamem=1 in DECODE; EXEC shows sel_a=10, sel_b=0, op_code=0, wr_acc=1.
- i_valid toggled low every other cycle: state, PC and strobes freeze; every strobe is 0 while i_valid=0.
- 2048 NOPs (opcode 11111): PC wraps from 2047 to 0; no write strobes occur.
- i_reset driven low in the EXEC of an ADDI, between clock edges: outputs clear immediately, and state=IDLE with PC=0.
